parity_block_packer: RTL



---
 rtl/parity_block_packer_if.sv | 27 ++
 rtl/parity_block_packer.sv | 107 ++++++++++
 2 files changed

// File: rtl/parity_block_packer_if.sv
// Word-in / block-out handshake bundle for the parity block packer.
// The master side feeds words and consumes blocks; the slave side is the packer.
interface parity_block_packer_if #(
    parameter int WORD_WIDTH = 64,
    parameter int DATA_WIDTH = 1024
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [4:0]            out_words;
    logic                  out_padded;
    logic [15:0]           blk_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_words, out_padded, blk_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_words, out_padded, blk_count
    );
endinterface

// File: rtl/parity_block_packer.sv
// Packs 64-bit words into 16-word blocks for the 1024-bit parity stage.
// Short frames close early on in_last; unused slots stay zero (parity-neutral).
module parity_block_packer #(
    parameter int WORD_WIDTH      = 64,
    parameter int WORDS_PER_BLOCK = 16,
    parameter int DATA_WIDTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parity_block_packer_if.slave  bus
);
    localparam int PTR_W = $clog2(WORDS_PER_BLOCK);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [4:0]            words_q, words_d;
    logic                  padded_q, padded_d;
    logic [15:0]           blk_q, blk_d;
    logic                  in_ready;
    logic                  accept;
    logic                  xfer;
    logic                  last_slot;

    assign in_ready  = (state_q == FILL) || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign xfer      = (state_q == HOLD) && bus.out_ready;
    assign last_slot = (ptr_q == PTR_W'(WORDS_PER_BLOCK - 1));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        fill_d   = fill_q;
        words_d  = words_q;
        padded_d = padded_q;
        blk_d    = blk_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int s = 0; s < WORDS_PER_BLOCK; s++) begin
                        if (ptr_q == PTR_W'(s)) begin
                            fill_d[s*WORD_WIDTH +: WORD_WIDTH] = bus.in_data;
                        end
                    end
                    if (last_slot || bus.in_last) begin
                        state_d  = HOLD;
                        ptr_d    = '0;
                        words_d  = 5'(ptr_q) + 5'd1;
                        padded_d = !last_slot;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    // The leaving block frees the register; a word arriving in the
                    // same cycle lands in slot 0 of a cleared block.
                    blk_d    = blk_q + 16'd1;
                    fill_d   = '0;
                    ptr_d    = '0;
                    words_d  = 5'd0;
                    padded_d = 1'b0;
                    state_d  = FILL;
                    if (accept) begin
                        fill_d[WORD_WIDTH-1:0] = bus.in_data;
                        if (bus.in_last) begin
                            state_d  = HOLD;
                            words_d  = 5'd1;
                            padded_d = 1'b1;
                        end else begin
                            ptr_d = PTR_W'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            ptr_q    <= '0;
            fill_q   <= '0;
            words_q  <= 5'd0;
            padded_q <= 1'b0;
            blk_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            fill_q   <= fill_d;
            words_q  <= words_d;
            padded_q <= padded_d;
            blk_q    <= blk_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_data   = fill_q;
    assign bus.out_words  = words_q;
    assign bus.out_padded = padded_q;
    assign bus.blk_count  = blk_q;
endmodule
